// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   ALU operation encodings shared by alu_decoder (producer of the code) and
//   the execute stage (alu_exec_unit / alu_core, consumers of the code).
//   Contents:
//     ALU_CTRL_W      width of the alu_control code
//     ALU_AND..SLT    defined operation codes; every other code is illegal
//     alu_op_e        enum view of the defined codes
//     alu_is_legal()  true for a defined code
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

  typedef enum logic [ALU_CTRL_W-1:0] {
    AluAnd = ALU_AND,
    AluOr  = ALU_OR,
    AluAdd = ALU_ADD,
    AluSub = ALU_SUB,
    AluSlt = ALU_SLT
  } alu_op_e;

  function automatic logic alu_is_legal(input logic [ALU_CTRL_W-1:0] code);
    return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
           (code == ALU_SUB) || (code == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU datapath, placed between the S1 and S2 registers
//   of alu_exec_unit.
//   Ports:
//     i_alu_control  operation code (alu_pkg encodings)
//     i_src_a        operand A
//     i_src_b        operand B
//     o_result       computed result (0 for an undefined code)
//     o_illegal      1 when i_alu_control is not a defined code
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [ALU_CTRL_W-1:0] i_alu_control,
  input  logic [XLEN-1:0]       i_src_a,
  input  logic [XLEN-1:0]       i_src_b,
  output logic [XLEN-1:0]       o_result,
  output logic                  o_illegal
);

  logic w_lt_signed;

  assign w_lt_signed = $signed(i_src_a) < $signed(i_src_b);

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_alu_control)
      ALU_AND: o_result = i_src_a & i_src_b;
      ALU_OR:  o_result = i_src_a | i_src_b;
      // ADD/SUB wrap modulo 2^XLEN; carry and overflow are intentionally dropped.
      ALU_ADD: o_result = i_src_a + i_src_b;
      ALU_SUB: o_result = i_src_a - i_src_b;
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, w_lt_signed};
      default: begin
        o_result  = '0;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Two-stage execute unit. S1 captures the operation on accept, alu_core
//   evaluates it, S2 captures result/flags/tag. All result-side outputs come
//   straight from S2 registers.
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     i_flush           synchronous kill of everything in flight
//     i_in_valid        operation offered
//     o_in_ready        operation can be accepted this cycle
//     i_alu_control     operation code
//     i_src_a/i_src_b   operands
//     i_in_tag          opaque tag returned with the result
//     o_out_valid       result offered
//     i_out_ready       consumer takes the result this cycle
//     o_result          result
//     o_zero            result == 0
//     o_illegal         code was undefined
//     o_out_tag         tag of the offered result
//     o_op_count        completed output transfers, saturating
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [ALU_CTRL_W-1:0] i_alu_control,
  input  logic [XLEN-1:0]       i_src_a,
  input  logic [XLEN-1:0]       i_src_b,
  input  logic [TAG_W-1:0]      i_in_tag,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [XLEN-1:0]       o_result,
  output logic                  o_zero,
  output logic                  o_illegal,
  output logic [TAG_W-1:0]      o_out_tag,
  output logic [CNT_W-1:0]      o_op_count
);

  // S1 registers
  logic                  r_s1_valid;
  logic [ALU_CTRL_W-1:0] r_s1_ctrl;
  logic [XLEN-1:0]       r_s1_a;
  logic [XLEN-1:0]       r_s1_b;
  logic [TAG_W-1:0]      r_s1_tag;

  // S2 registers
  logic                  r_s2_valid;
  logic [XLEN-1:0]       r_s2_result;
  logic                  r_s2_zero;
  logic                  r_s2_illegal;
  logic [TAG_W-1:0]      r_s2_tag;

  logic [CNT_W-1:0]      r_op_count;

  logic                  w_s2_drain;
  logic                  w_s2_free;
  logic                  w_s1_advance;
  logic                  w_accept;
  logic [XLEN-1:0]       w_core_result;
  logic                  w_core_illegal;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .i_alu_control (r_s1_ctrl),
    .i_src_a       (r_s1_a),
    .i_src_b       (r_s1_b),
    .o_result      (w_core_result),
    .o_illegal     (w_core_illegal)
  );

  // S2 may take a new op when empty or when its current op leaves this cycle.
  assign w_s2_drain   = r_s2_valid && i_out_ready;
  assign w_s2_free    = !r_s2_valid || w_s2_drain;
  assign w_s1_advance = r_s1_valid && w_s2_free;
  // Flush blocks acceptance so nothing offered in the flush cycle survives it.
  assign o_in_ready   = !i_flush && (!r_s1_valid || w_s1_advance);
  assign w_accept     = i_in_valid && o_in_ready;

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_ctrl  <= i_alu_control;
      r_s1_a     <= i_src_a;
      r_s1_b     <= i_src_b;
      r_s1_tag   <= i_in_tag;
    end else if (w_s1_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: result capture. Data registers only load on advance, which keeps
  // them stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_zero    <= 1'b0;
      r_s2_illegal <= 1'b0;
      r_s2_tag     <= '0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s1_advance) begin
      r_s2_valid   <= 1'b1;
      r_s2_result  <= w_core_result;
      r_s2_zero    <= (w_core_result == '0);
      r_s2_illegal <= w_core_illegal;
      r_s2_tag     <= r_s1_tag;
    end else if (w_s2_drain) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Completed-transfer counter. A transfer in the flush cycle still completes,
  // so flush does not gate it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_s2_drain && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign o_out_valid = r_s2_valid;
  assign o_result    = r_s2_result;
  assign o_zero      = r_s2_zero;
  assign o_illegal   = r_s2_illegal;
  assign o_out_tag   = r_s2_tag;
  assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic [3:0]       ctrl      = '0;
  logic [XLEN-1:0]  a         = '0;
  logic [XLEN-1:0]  b         = '0;
  logic [TAG_W-1:0] tag       = '0;

  logic             in_ready;
  logic             out_valid;
  logic [XLEN-1:0]  result;
  logic             zero;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] op_count;

  logic             sat_in_ready;
  logic             sat_out_valid;
  logic [XLEN-1:0]  sat_result;
  logic             sat_zero;
  logic             sat_illegal;
  logic [TAG_W-1:0] sat_out_tag;
  logic [1:0]       sat_op_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic             zero;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (flush),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_alu_control (ctrl),
    .i_src_a       (a),
    .i_src_b       (b),
    .i_in_tag      (tag),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_result      (result),
    .o_zero        (zero),
    .o_illegal     (illegal),
    .o_out_tag     (out_tag),
    .o_op_count    (op_count)
  );

  // Same stimulus, narrow counter, for the saturation check.
  alu_exec_unit #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W),
    .CNT_W (2)
  ) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (flush),
    .i_in_valid    (in_valid),
    .o_in_ready    (sat_in_ready),
    .i_alu_control (ctrl),
    .i_src_a       (a),
    .i_src_b       (b),
    .i_in_tag      (tag),
    .o_out_valid   (sat_out_valid),
    .i_out_ready   (out_ready),
    .o_result      (sat_result),
    .o_zero        (sat_zero),
    .o_illegal     (sat_illegal),
    .o_out_tag     (sat_out_tag),
    .o_op_count    (sat_op_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] x,
                                 input logic [XLEN-1:0] y, input logic [TAG_W-1:0] t);
    exp_t e;
    e.ill = 1'b0;
    e.tag = t;
    case (c)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: e.res = x + y;
      4'b0110: e.res = x - y;
      4'b0111: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard consumer: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_result", 64'(result), 64'(e.res));
        check("out_zero", 64'(zero), 64'(e.zero));
        check("out_illegal", 64'(illegal), 64'(e.ill));
        check("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  // Offer one op; returns just after the accepting rising edge.
  task automatic send(input logic [3:0] c, input logic [XLEN-1:0] x,
                      input logic [XLEN-1:0] y, input logic [TAG_W-1:0] t);
    bit ok;
    ok       = 1'b0;
    ctrl     = c;
    a        = x;
    b        = y;
    tag      = t;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", {63'd0, ok}, 64'd1);
    if (ok) sb.push_back(model(c, x, y, t));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int              acc;
    bit              have;
    logic [XLEN-1:0] snap_res;
    logic [TAG_W-1:0] snap_tag;
    logic [CNT_W-1:0] cnt0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // ADD latency: accepted in cycle N, visible in cycle N+2
    send(4'b0010, 32'd7, 32'd5, 5'd1);
    @(negedge clk);
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_result", 64'(result), 64'd12);
    @(posedge clk);
    #1;
    drain();
    check("cnt_after_one", 64'(op_count), 64'd1);

    // Reset while an op is in flight discards everything
    send(4'b0010, 32'd1, 32'd2, 5'd9);
    rst_n = 1'b0;
    sb.delete();
    #2;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("midrst_no_ghost", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Directed ops, back to back, out_ready=1
    send(4'b0010, 32'd7, 32'd5, 5'd2);
    send(4'b0110, 32'd5, 32'd5, 5'd3);
    send(4'b0000, 32'hF0, 32'h3C, 5'd4);
    send(4'b0001, 32'hF0, 32'h0F, 5'd5);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd6);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd7);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd8);
    send(4'b1111, 32'd3, 32'd4, 5'd31);
    drain();
    check("cnt_after_eight", 64'(op_count), 64'd8);
    check("sat_cnt", 64'(sat_op_count), 64'd3);

    // Backpressure: 4 ADDs with out_ready low for 5 cycles
    cnt0      = op_count;
    out_ready = 1'b0;
    acc       = 0;
    have      = 1'b0;
    snap_res  = '0;
    snap_tag  = '0;
    ctrl      = 4'b0010;
    a         = 32'd10;
    b         = 32'd1;
    tag       = 5'd1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin
          have     = 1'b1;
          snap_res = result;
          snap_tag = out_tag;
        end else begin
          check("hold_result", 64'(result), 64'(snap_res));
          check("hold_tag", 64'(out_tag), 64'(snap_tag));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(ctrl, a, b, tag));
        acc++;
      end
      @(posedge clk);
      #1;
      a   = 32'(10 * (acc + 1));
      b   = 32'(acc + 1);
      tag = 5'(acc + 1);
    end
    @(negedge clk);
    check("bp_accepts", 64'(acc), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_head_tag", 64'(out_tag), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (acc >= 4) break;
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(ctrl, a, b, tag));
        acc++;
      end
      @(posedge clk);
      #1;
      a   = 32'(10 * (acc + 1));
      b   = 32'(acc + 1);
      tag = 5'(acc + 1);
    end
    in_valid = 1'b0;
    check("bp_total_accepts", 64'(acc), 64'd4);
    drain();
    check("bp_op_count", 64'(op_count), 64'(cnt0) + 64'd4);

    // Flush with two ops in flight
    out_ready = 1'b0;
    send(4'b0010, 32'd100, 32'd1, 5'd5);
    send(4'b0010, 32'd200, 32'd2, 5'd6);
    cnt0     = op_count;
    flush    = 1'b1;
    ctrl     = 4'b0010;
    a        = 32'd300;
    b        = 32'd3;
    tag      = 5'd7;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_two_inflight", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_op_count", 64'(op_count), 64'(cnt0));
    @(negedge clk);
    check("flush_s1_empty", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'b0010, 32'd7, 32'd5, 5'd8);
    @(negedge clk);
    check("postflush_n1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("postflush_n2_valid", 64'(out_valid), 64'd1);
    check("postflush_tag", 64'(out_tag), 64'd8);
    @(posedge clk);
    #1;
    drain();
    check("postflush_op_count", 64'(op_count), 64'(cnt0) + 64'd1);
    check("sat_cnt_end", 64'(sat_op_count), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
